// File: rtl/palette_arbiter.sv
// palette_arbiter: two-port round-robin arbiter in front of a shared
// 13-entry palette ROM, followed by a 2-stage lookup pipeline that returns
// tagged RGB, a transparency flag and a sticky out-of-range error.
module palette_arbiter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_a_valid,
    input  logic [3:0]  i_a_index,
    output logic        o_a_ready,
    input  logic        i_b_valid,
    input  logic [3:0]  i_b_index,
    output logic        o_b_ready,
    output logic [3:0]  o_rom_addr,
    input  logic [23:0] i_rom_data,
    output logic        o_a_resp_valid,
    output logic        o_b_resp_valid,
    output logic [23:0] o_resp_color,
    output logic        o_resp_transparent,
    output logic        o_err_oob,
    input  logic        i_err_clear
);

    localparam int unsigned IDX_W             = 4;
    localparam int unsigned COLOR_W           = 24;
    localparam int unsigned NUM_ENTRIES       = 13;
    localparam int unsigned TRANSPARENT_INDEX = 0;

    typedef enum logic {
        TAG_A = 1'b0,
        TAG_B = 1'b1
    } tag_e;

    tag_e             r_rr_ptr;
    logic             r_s1_valid;
    tag_e             r_s1_tag;
    logic [IDX_W-1:0] r_s1_index;

    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_grant;
    tag_e             w_grant_tag;
    logic [IDX_W-1:0] w_grant_index;
    logic             w_s1_oob;

    // Grant selection: single requester wins outright, ties follow rr_ptr.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (i_enable) begin
            if (i_a_valid && i_b_valid) begin
                w_grant_a = (r_rr_ptr == TAG_A);
                w_grant_b = (r_rr_ptr == TAG_B);
            end else begin
                w_grant_a = i_a_valid;
                w_grant_b = i_b_valid;
            end
        end
    end

    assign o_a_ready     = w_grant_a;
    assign o_b_ready     = w_grant_b;
    assign w_grant       = w_grant_a | w_grant_b;
    assign w_grant_tag   = w_grant_b ? TAG_B : TAG_A;
    assign w_grant_index = w_grant_b ? i_b_index : i_a_index;
    assign w_s1_oob      = (r_s1_index >= IDX_W'(NUM_ENTRIES));

    // Round-robin pointer: always points at the port that did not win.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr_ptr <= TAG_A;
        end else if (w_grant_a) begin
            r_rr_ptr <= TAG_B;
        end else if (w_grant_b) begin
            r_rr_ptr <= TAG_A;
        end
    end

    // Stage 1: capture the granted request; its index addresses the ROM.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_tag   <= TAG_A;
            r_s1_index <= '0;
        end else begin
            r_s1_valid <= w_grant;
            if (w_grant) begin
                r_s1_tag   <= w_grant_tag;
                r_s1_index <= w_grant_index;
            end
        end
    end

    assign o_rom_addr = r_s1_index;

    // Stage 2: register ROM data, masking out-of-range entries to black.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_a_resp_valid     <= 1'b0;
            o_b_resp_valid     <= 1'b0;
            o_resp_color       <= '0;
            o_resp_transparent <= 1'b0;
        end else begin
            o_a_resp_valid     <= r_s1_valid && (r_s1_tag == TAG_A);
            o_b_resp_valid     <= r_s1_valid && (r_s1_tag == TAG_B);
            o_resp_color       <= w_s1_oob ? COLOR_W'(0) : i_rom_data;
            o_resp_transparent <= (r_s1_index == IDX_W'(TRANSPARENT_INDEX));
        end
    end

    // Sticky out-of-range flag; a new error beats a simultaneous clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err_oob <= 1'b0;
        end else if (r_s1_valid && w_s1_oob) begin
            o_err_oob <= 1'b1;
        end else if (i_err_clear) begin
            o_err_oob <= 1'b0;
        end
    end

endmodule

// File: tb/tb_palette_arbiter.sv
// Testbench for palette_arbiter: directed requests with hand-computed
// grants; expected responses queue up and a negedge monitor checks them.
module tb_palette_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        a_valid;
    logic [3:0]  a_index;
    logic        a_ready;
    logic        b_valid;
    logic [3:0]  b_index;
    logic        b_ready;
    logic [3:0]  rom_addr;
    logic [23:0] rom_data;
    logic        a_resp_valid;
    logic        b_resp_valid;
    logic [23:0] resp_color;
    logic        resp_transparent;
    logic        err_oob;
    logic        err_clear;

    typedef struct {
        logic        tag;      // 0 = A, 1 = B
        logic [23:0] color;
        logic        transp;
        int          at_edge;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] pal[16];
    int          edge_cnt = 0;
    int          total = 0;
    int          bad = 0;

    palette_arbiter dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_enable           (enable),
        .i_a_valid          (a_valid),
        .i_a_index          (a_index),
        .o_a_ready          (a_ready),
        .i_b_valid          (b_valid),
        .i_b_index          (b_index),
        .o_b_ready          (b_ready),
        .o_rom_addr         (rom_addr),
        .i_rom_data         (rom_data),
        .o_a_resp_valid     (a_resp_valid),
        .o_b_resp_valid     (b_resp_valid),
        .o_resp_color       (resp_color),
        .o_resp_transparent (resp_transparent),
        .o_err_oob          (err_oob),
        .i_err_clear        (err_clear)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Combinational palette ROM; entries 13..15 hold junk that must never appear.
    always_comb rom_data = pal[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every presented response must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (a_resp_valid || b_resp_valid)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_resp: a=%0b b=%0b color=%06h at edge %0d",
                         a_resp_valid, b_resp_valid, resp_color, edge_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (a_resp_valid !== !e.tag || b_resp_valid !== e.tag ||
                    resp_color !== e.color || resp_transparent !== e.transp ||
                    edge_cnt != e.at_edge) begin
                    bad++;
                    $display("FAIL resp: got a=%0b b=%0b color=%06h tr=%0b edge=%0d expected tag=%0b color=%06h tr=%0b edge=%0d",
                             a_resp_valid, b_resp_valid, resp_color, resp_transparent, edge_cnt,
                             e.tag, e.color, e.transp, e.at_edge);
                end
            end
        end
    end

    // One request cycle: drive, check readies, pass the edge, queue the response.
    task automatic cyc(input logic av, input logic [3:0] ai, input logic bv, input logic [3:0] bi,
                       input logic en, input logic ea, input logic eb,
                       input logic [23:0] col, input logic tr, input logic push);
        exp_t e;
        a_valid = av; a_index = ai; b_valid = bv; b_index = bi; enable = en;
        #2;
        check("a_ready", 32'(a_ready), 32'(ea));
        check("b_ready", 32'(b_ready), 32'(eb));
        @(posedge clk);
        #1;
        if (push && (ea || eb)) begin
            e.tag = eb; e.color = col; e.transp = tr; e.at_edge = edge_cnt + 1;
            sb.push_back(e);
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 4'd0, 0, 4'd0, 1, 0, 0, 24'h0, 0, 0);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_a_resp"}, 32'(a_resp_valid), 32'd0);
        check({name, "_b_resp"}, 32'(b_resp_valid), 32'd0);
        check({name, "_color"},  32'(resp_color), 32'd0);
        check({name, "_transp"}, 32'(resp_transparent), 32'd0);
        check({name, "_err"},    32'(err_oob), 32'd0);
        check({name, "_addr"},   32'(rom_addr), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pal[0]  = 24'hFF00FF; pal[1]  = 24'h000000; pal[2]  = 24'hFFFFFF; pal[3]  = 24'h808080;
        pal[4]  = 24'h00FF00; pal[5]  = 24'h0000FF; pal[6]  = 24'h00FFFF; pal[7]  = 24'hFF0000;
        pal[8]  = 24'hFF8000; pal[9]  = 24'hFFFF00; pal[10] = 24'h400040; pal[11] = 24'h0084FF;
        pal[12] = 24'h204060; pal[13] = 24'h123456; pal[14] = 24'hABCDEF; pal[15] = 24'hDEADBE;

        rst = 1'b1; enable = 1'b1; err_clear = 1'b0;
        a_valid = 1'b0; a_index = 4'd0; b_valid = 1'b0; b_index = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b0;

        // Tie: A first after reset, then strict alternation.
        cyc(1, 4'd9, 1, 4'd11, 1, 1, 0, 24'hFFFF00, 0, 1);
        cyc(1, 4'd9, 1, 4'd11, 1, 0, 1, 24'h0084FF, 0, 1);
        cyc(1, 4'd9, 1, 4'd11, 1, 1, 0, 24'hFFFF00, 0, 1);
        cyc(1, 4'd9, 1, 4'd11, 1, 0, 1, 24'h0084FF, 0, 1);
        idle(3);

        // A only, index 7.
        cyc(1, 4'd7, 0, 4'd0, 1, 1, 0, 24'hFF0000, 0, 1);
        idle(3);

        // B only, transparent key.
        cyc(0, 4'd0, 1, 4'd0, 1, 0, 1, 24'hFF00FF, 1, 1);
        idle(3);

        // Out-of-range index: black, not transparent, sticky error.
        check("err_before_oob", 32'(err_oob), 32'd0);
        cyc(1, 4'd14, 0, 4'd0, 1, 1, 0, 24'h000000, 0, 1);
        idle(3);
        check("err_set", 32'(err_oob), 32'd1);
        idle(2);
        check("err_sticky", 32'(err_oob), 32'd1);
        err_clear = 1'b1;
        idle(1);
        err_clear = 1'b0;
        check("err_cleared", 32'(err_oob), 32'd0);

        // Index 15 load coinciding with err_clear: set wins.
        cyc(1, 4'd15, 0, 4'd0, 1, 1, 0, 24'h000000, 0, 1);
        err_clear = 1'b1;
        idle(1);
        err_clear = 1'b0;
        check("err_set_wins", 32'(err_oob), 32'd1);
        err_clear = 1'b1;
        idle(1);
        err_clear = 1'b0;
        check("err_cleared2", 32'(err_oob), 32'd0);
        idle(2);

        // Disabled: no grants, rr_ptr (now B) holds across the gap.
        cyc(1, 4'd9, 1, 4'd11, 0, 0, 0, 24'h0, 0, 0);
        cyc(1, 4'd9, 1, 4'd11, 0, 0, 0, 24'h0, 0, 0);
        cyc(1, 4'd9, 1, 4'd11, 0, 0, 0, 24'h0, 0, 0);
        idle(2);
        cyc(1, 4'd9, 1, 4'd11, 1, 0, 1, 24'h0084FF, 0, 1);
        cyc(1, 4'd9, 1, 4'd11, 1, 1, 0, 24'hFFFF00, 0, 1);
        idle(3);

        // Reset right after a grant: the lookup is discarded.
        cyc(1, 4'd7, 0, 4'd0, 1, 1, 0, 24'hFF0000, 0, 0);
        rst = 1'b1;
        #2;
        check_quiet("midrst");
        repeat (3) @(posedge clk);
        #1;
        check_quiet("midrst_hold");
        rst = 1'b0;
        idle(4);

        // First grant after release: A wins the tie again, two-cycle latency.
        cyc(1, 4'd2, 1, 4'd5, 1, 1, 0, 24'hFFFFFF, 0, 1);
        cyc(1, 4'd2, 1, 4'd5, 1, 0, 1, 24'h0000FF, 0, 1);
        idle(4);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
